sbox_sched: RTL

Arbiter and sequencer that shares one 4-lane S-box datapath between two AES requesters: the key-expansion SubWord path (one 32-bit word) and the round SubBytes path (one 128-bit state, four words). It drives the 32-bit lane bus feeding four zero-latency S-box units, with one byte per unit. It collects the substituted bytes into registered results and returns them with a one-cycle completion pulse to the granted requester. It sits between the AES key-schedule/round controllers and the S-box units in the crypto accelerator.

---
 rtl/sbox_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sbox_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sbox_sched : shares one 4-lane S-box datapath between key and state paths
// Revision   : 1.0
// ---------------------------------------------------------------------------
module sbox_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_req,
  input  logic [31:0]  key_word,
  output logic         key_ack,
  output logic [31:0]  key_result,
  input  logic         st_req,
  input  logic [127:0] st_data,
  output logic         st_done,
  output logic [127:0] st_result,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_ST   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic                prio_q, prio_d;      // 0: key favoured, 1: state favoured
  logic [3:0][31:0]    op_q, op_d;
  logic [2:0][31:0]    shadow_q, shadow_d;
  logic [31:0]         key_res_q, key_res_d;
  logic [127:0]        st_res_q, st_res_d;
  logic                key_ack_q, key_ack_d;
  logic                st_done_q, st_done_d;
  logic                key_eff;
  logic                st_eff;

  // A requester is ignored in the cycle its own ack/done is showing.
  assign key_eff = key_req & ~key_ack_q;
  assign st_eff  = st_req  & ~st_done_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prio_d    = prio_q;
    op_d      = op_q;
    shadow_d  = shadow_q;
    key_res_d = key_res_q;
    st_res_d  = st_res_q;
    key_ack_d = 1'b0;
    st_done_d = 1'b0;
    sbox_in   = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (key_eff && (!st_eff || !prio_q)) begin
          state_d = S_KEY;
          op_d    = {96'd0, key_word};
          prio_d  = 1'b1;
        end else if (st_eff) begin
          state_d = S_ST;
          op_d    = st_data;
          idx_d   = 2'd0;
          prio_d  = 1'b0;
        end
      end
      S_KEY: begin
        sbox_in   = op_q[0];
        key_res_d = sbox_out;
        key_ack_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_ST: begin
        sbox_in = op_q[idx_q];
        if (idx_q == 2'd3) begin
          // Publish the whole state at once so no partial result is visible.
          st_res_d  = {sbox_out, shadow_q[2], shadow_q[1], shadow_q[0]};
          st_done_d = 1'b1;
          idx_d     = 2'd0;
          state_d   = S_IDLE;
        end else begin
          shadow_d[idx_q] = sbox_out;
          idx_d           = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      prio_q    <= 1'b0;
      op_q      <= '0;
      shadow_q  <= '0;
      key_res_q <= 32'd0;
      st_res_q  <= 128'd0;
      key_ack_q <= 1'b0;
      st_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prio_q    <= prio_d;
      op_q      <= op_d;
      shadow_q  <= shadow_d;
      key_res_q <= key_res_d;
      st_res_q  <= st_res_d;
      key_ack_q <= key_ack_d;
      st_done_q <= st_done_d;
    end
  end

  assign key_ack    = key_ack_q;
  assign st_done    = st_done_q;
  assign key_result = key_res_q;
  assign st_result  = st_res_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
